tlc_phase_scheduler: RTL and testbench

- Actuated phase scheduler for a two-approach intersection: north-south (NS) and east-west (EW).
- Decides which approach gets green, for how long, and when a pedestrian walk phase is inserted.
- Inputs are vehicle detectors and a pedestrian push-button; outputs are the registered light words that drive the intersection heads.
- Replaces the fixed-cycle sequencing of the current controller with demand-driven min/max green timing.

---
 rtl/tlc_pkg.sv | 25 ++
 rtl/tlc_tick_timer.sv | 40 ++++
 rtl/tlc_phase_scheduler.sv | 150 +++++++++++++++
 tb/tb_tlc_phase_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types for the traffic phase scheduler:
// state encoding, light words and walk-return direction.
package tlc_pkg;

  typedef enum logic [2:0] {
    NS_G     = 3'd0,
    NS_Y     = 3'd1,
    NS_AR    = 3'd2,
    EW_G     = 3'd3,
    EW_Y     = 3'd4,
    EW_AR    = 3'd5,
    PED_WALK = 3'd6,
    PED_CLR  = 3'd7
  } tlc_state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } tlc_dir_e;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

endpackage

// File: rtl/tlc_tick_timer.sv
// Tick prescaler plus saturating phase timer.
// Ports: en gates the prescaler, clear zeroes the timer; tick, timer out.
module tlc_tick_timer #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  output logic             tick,
  output logic [CNT_W-1:0] timer
);

  localparam logic [CNT_W-1:0] PRE_LAST =
    CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] pre;

  assign tick = en && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (tick && (timer != '1)) begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Actuated NS/EW phase scheduler with min/max green and walk insertion.
// Ports: car_ns/car_ew/ped_req in; light words, walk, ped_pending, phase out.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MIN_GREEN    = 8,
  parameter int unsigned MAX_GREEN    = 20,
  parameter int unsigned YELLOW_TIME  = 3,
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned WALK_TIME    = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [2:0] light_north_south,
  output logic [2:0] light_east_west,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] MIN_L =
    CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_L =
    CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_L =
    CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_L =
    CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] WALK_L =
    CNT_W'(WALK_TIME - 1);

  tlc_state_e       state, state_n;
  tlc_dir_e         dir, dir_n;
  logic             pend, pend_n;
  logic             tick;
  logic [CNT_W-1:0] timer;
  logic [2:0]       ns_n, ew_n;
  logic             walk_n;

  tlc_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (1'b1),
    .clear (state_n != state),
    .tick  (tick),
    .timer (timer)
  );

  always_comb begin
    state_n = state;
    dir_n   = dir;
    if (tick) begin
      unique case (state)
        NS_G: begin
          if ((car_ew | pend) &&
              (timer >= MAX_L ||
               (timer >= MIN_L && !car_ns)))
            state_n = NS_Y;
        end
        NS_Y: if (timer == YEL_L) state_n = NS_AR;
        NS_AR: begin
          if (timer == AR_L) begin
            if (pend) begin
              state_n = PED_WALK;
              dir_n   = DIR_EW;
            end else begin
              state_n = EW_G;
            end
          end
        end
        EW_G: begin
          if ((car_ns | pend) &&
              (timer >= MAX_L ||
               (timer >= MIN_L && !car_ew)))
            state_n = EW_Y;
        end
        EW_Y: if (timer == YEL_L) state_n = EW_AR;
        EW_AR: begin
          if (timer == AR_L) begin
            if (pend) begin
              state_n = PED_WALK;
              dir_n   = DIR_NS;
            end else begin
              state_n = NS_G;
            end
          end
        end
        PED_WALK: if (timer == WALK_L) state_n = PED_CLR;
        PED_CLR: begin
          if (timer == AR_L)
            state_n = (dir == DIR_EW) ? EW_G : NS_G;
        end
      endcase
    end
  end

  // Entering the walk serves the request; a press in that cycle is lost.
  always_comb begin
    pend_n = pend;
    if (state_n == PED_WALK && state != PED_WALK)
      pend_n = 1'b0;
    else if (ped_req && state != PED_WALK)
      pend_n = 1'b1;
  end

  // Decode from the next state so the registered heads track the state.
  always_comb begin
    ns_n   = LIGHT_RED;
    ew_n   = LIGHT_RED;
    walk_n = 1'b0;
    unique case (1'b1)
      (state_n == NS_G):     ns_n   = LIGHT_GRN;
      (state_n == NS_Y):     ns_n   = LIGHT_YEL;
      (state_n == EW_G):     ew_n   = LIGHT_GRN;
      (state_n == EW_Y):     ew_n   = LIGHT_YEL;
      (state_n == PED_WALK): walk_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= EW_AR;
      dir               <= DIR_NS;
      pend              <= 1'b0;
      light_north_south <= LIGHT_RED;
      light_east_west   <= LIGHT_RED;
      walk              <= 1'b0;
    end else begin
      state             <= state_n;
      dir               <= dir_n;
      pend              <= pend_n;
      light_north_south <= ns_n;
      light_east_west   <= ew_n;
      walk              <= walk_n;
    end
  end

  assign ped_pending = pend;
  assign phase       = state;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench: phase-segment tables run on two instances
// (TICK_DIV=1 and TICK_DIV=4), plus an async reset mid-yellow sequence.
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  logic clk = 1'b0;
  logic rst1_n = 1'b0;
  logic rst4_n = 1'b0;
  logic car_ns = 1'b0;
  logic car_ew = 1'b0;
  logic ped_req = 1'b0;

  logic [2:0] ns1, ew1, ph1, ns4, ew4, ph4;
  logic       wk1, pd1, wk4, pd4;

  int total = 0;
  int bad = 0;
  bit sel4 = 1'b0;

  localparam logic [2:0] R = LIGHT_RED;
  localparam logic [2:0] Y = LIGHT_YEL;
  localparam logic [2:0] G = LIGHT_GRN;

  always #5 clk = ~clk;

  tlc_phase_scheduler #(.TICK_DIV(1)) dut1 (
    .clk               (clk),
    .reset_n           (rst1_n),
    .car_ns            (car_ns),
    .car_ew            (car_ew),
    .ped_req           (ped_req),
    .light_north_south (ns1),
    .light_east_west   (ew1),
    .walk              (wk1),
    .ped_pending       (pd1),
    .phase             (ph1)
  );

  tlc_phase_scheduler #(.TICK_DIV(4)) dut4 (
    .clk               (clk),
    .reset_n           (rst4_n),
    .car_ns            (car_ns),
    .car_ew            (car_ew),
    .ped_req           (ped_req),
    .light_north_south (ns4),
    .light_east_west   (ew4),
    .walk              (wk4),
    .ped_pending       (pd4),
    .phase             (ph4)
  );

  // Conflicting heads must never both show non-red.
  always @(negedge clk) begin
    total++;
    if (ns1 !== R && ew1 !== R) begin
      bad++;
      $display("FAIL safety1 ns=%b ew=%b want one red",
               ns1, ew1);
    end
    total++;
    if (ns4 !== R && ew4 !== R) begin
      bad++;
      $display("FAIL safety4 ns=%b ew=%b want one red",
               ns4, ew4);
    end
  end

  typedef struct {
    string      nm;
    bit         rst;
    bit         sel;
    bit         cn;
    bit         ce;
    int         ped_at;
    int         n;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    logic       pd;
  } seg_t;

  seg_t tab[$];

  function automatic seg_t mk(
    string nm, bit rst, bit sel, bit cn, bit ce,
    int ped_at, int n, logic [2:0] ns, logic [2:0] ew,
    logic wk, logic pd);
    seg_t s;
    s.nm = nm; s.rst = rst; s.sel = sel;
    s.cn = cn; s.ce = ce; s.ped_at = ped_at;
    s.n = n; s.ns = ns; s.ew = ew;
    s.wk = wk; s.pd = pd;
    return s;
  endfunction

  task automatic do_reset(bit sel);
    ped_req = 1'b0;
    if (sel) rst4_n = 1'b0;
    else     rst1_n = 1'b0;
    repeat (2) @(negedge clk);
    if (sel) rst4_n = 1'b1;
    else     rst1_n = 1'b1;
  endtask

  task automatic run(seg_t s);
    logic [2:0] ns, ew;
    logic       wk, pd;
    if (s.rst) do_reset(s.sel);
    sel4 = s.sel;
    for (int i = 0; i < s.n; i++) begin
      car_ns  = s.cn;
      car_ew  = s.ce;
      ped_req = (i == s.ped_at);
      ns = sel4 ? ns4 : ns1;
      ew = sel4 ? ew4 : ew1;
      wk = sel4 ? wk4 : wk1;
      pd = sel4 ? pd4 : pd1;
      total++;
      if (ns !== s.ns || ew !== s.ew ||
          wk !== s.wk || pd !== s.pd) begin
        bad++;
        $display({"FAIL %s[%0d] got ns=%b ew=%b walk=%b",
                  " pend=%b want ns=%b ew=%b walk=%b pend=%b"},
                 s.nm, i, ns, ew, wk, pd,
                 s.ns, s.ew, s.wk, s.pd);
      end
      @(negedge clk);
    end
    ped_req = 1'b0;
  endtask

  task automatic chk(string nm, logic [7:0] got,
                     logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);

    // idle
    tab.push_back(mk("i_ar", 1, 0, 0, 0, -1, 2, R, R, 0, 0));
    tab.push_back(mk("i_ng", 0, 0, 0, 0, -1, 100, G, R, 0, 0));
    // gap-out
    tab.push_back(mk("g_ar", 1, 0, 0, 1, -1, 2, R, R, 0, 0));
    tab.push_back(mk("g_ng", 0, 0, 0, 1, -1, 8, G, R, 0, 0));
    tab.push_back(mk("g_ny", 0, 0, 0, 1, -1, 3, Y, R, 0, 0));
    tab.push_back(mk("g_nar", 0, 0, 0, 1, -1, 2, R, R, 0, 0));
    tab.push_back(mk("g_eg", 0, 0, 0, 1, -1, 40, R, G, 0, 0));
    // max-out, two full 50-cycle periods
    tab.push_back(mk("m_ar", 1, 0, 1, 1, -1, 2, R, R, 0, 0));
    for (int k = 0; k < 2; k++) begin
      tab.push_back(mk("m_ng", 0, 0, 1, 1, -1, 20, G, R, 0, 0));
      tab.push_back(mk("m_ny", 0, 0, 1, 1, -1, 3, Y, R, 0, 0));
      tab.push_back(mk("m_nar", 0, 0, 1, 1, -1, 2, R, R, 0, 0));
      tab.push_back(mk("m_eg", 0, 0, 1, 1, -1, 20, R, G, 0, 0));
      tab.push_back(mk("m_ey", 0, 0, 1, 1, -1, 3, R, Y, 0, 0));
      tab.push_back(mk("m_ear", 0, 0, 1, 1, -1, 2, R, R, 0, 0));
    end
    // pedestrian: press on the third NS_G cycle
    tab.push_back(mk("w_ar", 1, 0, 0, 0, -1, 2, R, R, 0, 0));
    tab.push_back(mk("w_g1", 0, 0, 0, 0, 2, 3, G, R, 0, 0));
    tab.push_back(mk("w_g2", 0, 0, 0, 0, -1, 5, G, R, 0, 1));
    tab.push_back(mk("w_y", 0, 0, 0, 0, -1, 3, Y, R, 0, 1));
    tab.push_back(mk("w_nar", 0, 0, 0, 0, -1, 2, R, R, 0, 1));
    tab.push_back(mk("w_wk", 0, 0, 0, 0, -1, 6, R, R, 1, 0));
    tab.push_back(mk("w_clr", 0, 0, 0, 0, -1, 2, R, R, 0, 0));
    tab.push_back(mk("w_eg", 0, 0, 0, 0, -1, 20, R, G, 0, 0));
    // reset mid-yellow, with a request pending
    tab.push_back(mk("r_ar", 1, 0, 0, 1, -1, 2, R, R, 0, 0));
    tab.push_back(mk("r_g1", 0, 0, 0, 1, 2, 3, G, R, 0, 0));
    tab.push_back(mk("r_g2", 0, 0, 0, 1, -1, 5, G, R, 0, 1));
    tab.push_back(mk("r_y", 0, 0, 0, 1, -1, 1, Y, R, 0, 1));
    foreach (tab[i]) run(tab[i]);
    tab.delete();

    #2 rst1_n = 1'b0;
    #1;
    chk("rst_ns", {5'd0, ns1}, {5'd0, R});
    chk("rst_ew", {5'd0, ew1}, {5'd0, R});
    chk("rst_walk", {7'd0, wk1}, 8'd0);
    chk("rst_pend", {7'd0, pd1}, 8'd0);
    chk("rst_phase", {5'd0, ph1}, {5'd0, EW_AR});
    @(negedge clk);
    car_ew = 1'b0;
    rst1_n = 1'b1;
    tab.push_back(mk("rr_ar", 0, 0, 0, 0, -1, 2, R, R, 0, 0));
    tab.push_back(mk("rr_ng", 0, 0, 0, 0, -1, 10, G, R, 0, 0));

    // prescaled instance, gap-out then a press between ticks
    tab.push_back(mk("p_ar", 1, 1, 0, 1, -1, 8, R, R, 0, 0));
    tab.push_back(mk("p_ng", 0, 1, 0, 1, -1, 32, G, R, 0, 0));
    tab.push_back(mk("p_ny", 0, 1, 0, 1, -1, 12, Y, R, 0, 0));
    tab.push_back(mk("p_nar", 0, 1, 0, 1, -1, 8, R, R, 0, 0));
    tab.push_back(mk("p_eg", 0, 1, 0, 1, -1, 40, R, G, 0, 0));
    tab.push_back(mk("p_ped", 0, 1, 0, 1, 0, 1, R, G, 0, 0));
    tab.push_back(mk("p_eg2", 0, 1, 0, 1, -1, 39, R, G, 0, 1));
    tab.push_back(mk("p_ey", 0, 1, 0, 1, -1, 12, R, Y, 0, 1));
    tab.push_back(mk("p_ear", 0, 1, 0, 1, -1, 8, R, R, 0, 1));
    tab.push_back(mk("p_wk", 0, 1, 0, 1, -1, 24, R, R, 1, 0));
    tab.push_back(mk("p_clr", 0, 1, 0, 1, -1, 8, R, R, 0, 0));
    tab.push_back(mk("p_ng2", 0, 1, 0, 1, -1, 32, G, R, 0, 0));
    tab.push_back(mk("p_ny2", 0, 1, 0, 1, -1, 4, Y, R, 0, 0));
    foreach (tab[i]) run(tab[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
